// File: rtl/word_splitter_if.sv
// Stream bundle for word_splitter: a 2n-bit packed word in, n-bit halves out.
// slave modport is the splitter's side; master modport is the producer/consumer side.
// Signals: in_valid/in_ready/in_ab (word in), out_valid/out_ready/out_half/out_last (halves out).
interface word_splitter_if #(
  parameter int n = 8
);
  logic           in_valid;
  logic           in_ready;
  logic [2*n-1:0] in_ab;
  logic           out_valid;
  logic           out_ready;
  logic [n-1:0]   out_half;
  logic           out_last;

  modport slave (
    input  in_valid,
    input  in_ab,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_half,
    output out_last
  );

  modport master (
    output in_valid,
    output in_ab,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_half,
    input  out_last
  );
endinterface

// File: rtl/word_splitter.sv
// Purpose: unpacks one 2n-bit {a,b} word into two n-bit halves sent serially on a valid/ready stream.
// Latency: word accepted at edge T shows its first half in cycle T+1; one word per 2 cycles sustained.
// Backpressure: halves hold steady while out_ready is low; in_ready is combinational from out_ready
//   in SEND_SECOND so the next word can be latched on the same edge the last half leaves.
// Ports: clk, rst (async, active-high); bus (word_splitter_if.slave) carries both streams;
//   busy = not IDLE; word_cnt = accepted words modulo 2^CW.
// Build option: define SPLIT_LOW_FIRST_EN to send the low half (b) first instead of the high half (a).
module word_splitter #(
  parameter int n  = 8,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  word_splitter_if.slave bus,
  output logic          busy,
  output logic [CW-1:0] word_cnt
);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    SEND_FIRST  = 2'd1,
    SEND_SECOND = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [2*n-1:0]  hold_q, hold_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            in_xfer;
  logic            out_xfer;
  logic [n-1:0]    first_half;
  logic [n-1:0]    second_half;

`ifdef SPLIT_LOW_FIRST_EN
  assign first_half  = hold_q[n-1:0];
  assign second_half = hold_q[2*n-1:n];
`else
  assign first_half  = hold_q[2*n-1:n];
  assign second_half = hold_q[n-1:0];
`endif

  // Outputs decode straight from state and hold register: no output pipeline.
  assign bus.out_valid = (state_q != IDLE);
  assign bus.out_last  = (state_q == SEND_SECOND);
  assign bus.in_ready  = (state_q == IDLE) ||
                         ((state_q == SEND_SECOND) && bus.out_ready);
  assign busy          = (state_q != IDLE);
  assign word_cnt      = cnt_q;

  assign in_xfer  = bus.in_valid  && bus.in_ready;
  assign out_xfer = bus.out_valid && bus.out_ready;

  always_comb begin
    bus.out_half = '0;
    case (state_q)
      SEND_FIRST:  bus.out_half = first_half;
      SEND_SECOND: bus.out_half = second_half;
      default:     bus.out_half = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_xfer) begin
          hold_d  = bus.in_ab;
          cnt_d   = cnt_q + {{(CW-1){1'b0}}, 1'b1};
          state_d = SEND_FIRST;
        end
      end
      SEND_FIRST: begin
        if (out_xfer) state_d = SEND_SECOND;
      end
      SEND_SECOND: begin
        // in_xfer here implies out_ready, hence out_xfer: zero-bubble reload.
        if (out_xfer && in_xfer) begin
          hold_d  = bus.in_ab;
          cnt_d   = cnt_q + {{(CW-1){1'b0}}, 1'b1};
          state_d = SEND_FIRST;
        end else if (out_xfer) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      hold_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_word_splitter.sv
module tb_word_splitter;

  logic       clk;
  logic       rst;
  logic       busy, busy2;
  logic [7:0] word_cnt;
  logic [1:0] word_cnt2;

  int n_vec;
  int n_err;
  bit chk_en;

`ifdef SPLIT_LOW_FIRST_EN
  localparam bit LOWF = 1'b1;
`else
  localparam bit LOWF = 1'b0;
`endif

  word_splitter_if #(.n(8)) if0 ();
  word_splitter_if #(.n(8)) if2 ();

  word_splitter #(.n(8), .CW(8)) u_dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (if0.slave),
    .busy     (busy),
    .word_cnt (word_cnt)
  );

  // Narrow-counter instance sees the same stimulus.
  word_splitter #(.n(8), .CW(2)) u_dut2 (
    .clk      (clk),
    .rst      (rst),
    .bus      (if2.slave),
    .busy     (busy2),
    .word_cnt (word_cnt2)
  );

  assign if2.in_valid  = if0.in_valid;
  assign if2.in_ab     = if0.in_ab;
  assign if2.out_ready = if0.out_ready;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: a queue of halves still owed downstream plus a word counter.
  logic [7:0] q[$];
  int         m_cnt;

  function automatic bit m_in_ready();
    return (q.size() == 0) || (q.size() == 1 && if0.out_ready);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      m_cnt = 0;
    end else begin
      bit do_push;
      do_push = if0.in_valid && m_in_ready();
      if (q.size() > 0 && if0.out_ready) void'(q.pop_front());
      if (do_push) begin
        if (LOWF) begin
          q.push_back(if0.in_ab[7:0]);
          q.push_back(if0.in_ab[15:8]);
        end else begin
          q.push_back(if0.in_ab[15:8]);
          q.push_back(if0.in_ab[7:0]);
        end
        m_cnt = m_cnt + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready",  {31'd0, if0.in_ready},  {31'd0, m_in_ready()});
      chk("out_valid", {31'd0, if0.out_valid}, {31'd0, q.size() > 0});
      chk("out_half",  {24'd0, if0.out_half},  (q.size() > 0) ? {24'd0, q[0]} : 32'd0);
      chk("out_last",  {31'd0, if0.out_last},  {31'd0, q.size() == 1});
      chk("busy",      {31'd0, busy},          {31'd0, q.size() > 0});
      chk("word_cnt",  {24'd0, word_cnt},      m_cnt % 256);
      chk("word_cnt2", {30'd0, word_cnt2},     m_cnt % 4);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 100000");
    $fatal(1);
  end

  logic [1:0] cnt2_exp [4];

  initial begin
    n_vec = 0;
    n_err = 0;
    chk_en = 1'b0;
    rst = 1'b1;
    if0.in_valid  = 1'b0;
    if0.in_ab     = '0;
    if0.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk_en = 1'b1;
    #1;
    chk("rst_out_valid", {31'd0, if0.out_valid}, 32'd0);
    chk("rst_in_ready",  {31'd0, if0.in_ready},  32'd1);
    chk("rst_word_cnt",  {24'd0, word_cnt},      32'd0);

    // Single word, no stall.
    if0.in_valid = 1'b1; if0.in_ab = 16'hA55A; if0.out_ready = 1'b1;
    step();
    if0.in_valid = 1'b0;
    chk("a55a_first", {24'd0, if0.out_half}, LOWF ? 32'h5A : 32'hA5);
    chk("a55a_first_last", {31'd0, if0.out_last}, 32'd0);
    step();
    chk("a55a_second", {24'd0, if0.out_half}, LOWF ? 32'hA5 : 32'h5A);
    chk("a55a_second_last", {31'd0, if0.out_last}, 32'd1);
    step();
    chk("a55a_idle_busy", {31'd0, busy}, 32'd0);
    chk("a55a_cnt", {24'd0, word_cnt}, 32'd1);

    // Stall the first half for 3 cycles; in_valid held high but not accepted.
    if0.in_valid = 1'b1; if0.in_ab = 16'h1234; if0.out_ready = 1'b0;
    step();
    if0.in_ab = 16'hFFFF;
    for (int i = 0; i < 3; i++) begin
      chk("stall_half", {24'd0, if0.out_half}, LOWF ? 32'h34 : 32'h12);
      chk("stall_in_ready", {31'd0, if0.in_ready}, 32'd0);
      step();
    end
    if0.in_valid = 1'b0;
    if0.out_ready = 1'b1;
    #1;
    chk("stall_half4", {24'd0, if0.out_half}, LOWF ? 32'h34 : 32'h12);
    step();
    chk("stall_second", {24'd0, if0.out_half}, LOWF ? 32'h12 : 32'h34);
    step();
    chk("stall_cnt", {24'd0, word_cnt}, 32'd2);

    // Back-to-back words.
    if0.in_valid = 1'b1; if0.in_ab = 16'h1234; if0.out_ready = 1'b1;
    step();
    if0.in_ab = 16'hBEEF;
    chk("b2b_0", {24'd0, if0.out_half}, LOWF ? 32'h34 : 32'h12);
    step();
    chk("b2b_1", {24'd0, if0.out_half}, LOWF ? 32'h12 : 32'h34);
    chk("b2b_1_in_ready", {31'd0, if0.in_ready}, 32'd1);
    step();
    if0.in_valid = 1'b0;
    chk("b2b_2", {24'd0, if0.out_half}, LOWF ? 32'hEF : 32'hBE);
    step();
    chk("b2b_3", {24'd0, if0.out_half}, LOWF ? 32'hBE : 32'hEF);
    chk("b2b_3_last", {31'd0, if0.out_last}, 32'd1);
    step();
    chk("b2b_cnt", {24'd0, word_cnt}, 32'd4);

    // Asynchronous reset during SEND_SECOND.
    if0.in_valid = 1'b1; if0.in_ab = 16'hCAFE;
    step();
    if0.in_valid = 1'b0;
    step();
    chk("cafe_second", {24'd0, if0.out_half}, LOWF ? 32'hCA : 32'hFE);
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", {31'd0, if0.out_valid}, 32'd0);
    chk("arst_out_half",  {24'd0, if0.out_half},  32'd0);
    chk("arst_busy",      {31'd0, busy},          32'd0);
    chk("arst_cnt",       {24'd0, word_cnt},      32'd0);
    step();
    rst = 1'b0;
    if0.in_valid = 1'b1; if0.in_ab = 16'h0102;
    step();
    if0.in_valid = 1'b0;
    chk("w0102_first", {24'd0, if0.out_half}, LOWF ? 32'h02 : 32'h01);
    step();
    chk("w0102_second", {24'd0, if0.out_half}, LOWF ? 32'h01 : 32'h02);
    step();
    chk("w0102_cnt", {24'd0, word_cnt}, 32'd1);

    // Four more words: narrow counter wraps 2,3,0,1.
    cnt2_exp[0] = 2'd2; cnt2_exp[1] = 2'd3; cnt2_exp[2] = 2'd0; cnt2_exp[3] = 2'd1;
    for (int k = 0; k < 4; k++) begin
      if0.in_valid = 1'b1; if0.in_ab = 16'h1000 + 16'(k);
      step();
      if0.in_valid = 1'b0;
      chk("cnt2_wrap", {30'd0, word_cnt2}, {30'd0, cnt2_exp[k]});
      step();
      step();
    end
    chk("cnt_final", {24'd0, word_cnt}, 32'd5);

    repeat (2) step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
